stopwatch_time_counter: RTL and testbench

//  Downstream of the stopwatch control FSM. Consumes the FSM's registered enable
//  and accumulates elapsed time as six BCD digits, MM:SS.hh, for the display stage.
//  A prescaler converts the i_CLK rate (1 kHz) into 1/100 s ticks.

---
 rtl/stopwatch_time_counter.sv | 125 ++++++++++++
 tb/tb_stopwatch_time_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch elapsed-time counter: prescales the 1 kHz clock to 1/100 s ticks and
// accumulates MM:SS.hh as six BCD digits, wrapping 59:59.99 -> 00:00.00.
module stopwatch_time_counter #(
    parameter int P_PRESCALE   = 10,
    parameter int P_PRESCALE_W = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_ENABLE,
    input  logic        i_CLEAR,
    output logic [23:0] o_DIGITS,
    output logic        o_TICK,
    output logic        o_ROLLOVER
);

    localparam logic [P_PRESCALE_W-1:0] LP_PRE_LAST = P_PRESCALE_W'(P_PRESCALE - 1);
    localparam logic [P_PRESCALE_W-1:0] LP_PRE_ONE  = P_PRESCALE_W'(1);
    localparam logic [P_PRESCALE_W-1:0] LP_PRE_ZERO = P_PRESCALE_W'(0);

    logic [P_PRESCALE_W-1:0] r_prescale;
    logic [23:0]             r_digits;
    logic                    r_tick;
    logic                    r_rollover;

    logic                    w_tick_due;
    logic [23:0]             w_digits_next;
    logic [6:0]              w_carry;

    // One BCD digit of the ripple chain: returns {carry_out, next_digit}.
    // Out-of-range values collapse to zero without propagating a carry.
    function automatic logic [4:0] f_bcd_step(
        input logic [3:0] d,
        input logic [3:0] max,
        input logic       cin
    );
        logic [4:0] res;
        if (d > max) begin
            res = {1'b0, 4'd0};
        end else if (!cin) begin
            res = {1'b0, d};
        end else if (d == max) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

    // Tick-due decode and next-time ripple chain (H0 -> H1 -> S0 -> S1 -> M0 -> M1).
    always_comb begin
        w_tick_due    = i_ENABLE && (r_prescale == LP_PRE_LAST);
        w_carry       = 7'd0;
        w_digits_next = 24'h000000;
        w_carry[0]    = 1'b1;
        {w_carry[1], w_digits_next[3:0]}   = f_bcd_step(r_digits[3:0],   4'd9, w_carry[0]);
        {w_carry[2], w_digits_next[7:4]}   = f_bcd_step(r_digits[7:4],   4'd9, w_carry[1]);
        {w_carry[3], w_digits_next[11:8]}  = f_bcd_step(r_digits[11:8],  4'd9, w_carry[2]);
        {w_carry[4], w_digits_next[15:12]} = f_bcd_step(r_digits[15:12], 4'd5, w_carry[3]);
        {w_carry[5], w_digits_next[19:16]} = f_bcd_step(r_digits[19:16], 4'd9, w_carry[4]);
        {w_carry[6], w_digits_next[23:20]} = f_bcd_step(r_digits[23:20], 4'd5, w_carry[5]);
    end

    // Prescaler, time digits and the registered tick/rollover pulses.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_prescale <= LP_PRE_ZERO;
            r_digits   <= 24'h000000;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (i_CLEAR) begin
            r_prescale <= LP_PRE_ZERO;
            r_digits   <= 24'h000000;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (w_tick_due) begin
            r_prescale <= LP_PRE_ZERO;
            r_digits   <= w_digits_next;
            r_tick     <= 1'b1;
            r_rollover <= w_carry[6];
        end else if (i_ENABLE) begin
            r_prescale <= r_prescale + LP_PRE_ONE;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end
    end

    assign o_DIGITS   = r_digits;
    assign o_TICK     = r_tick;
    assign o_ROLLOVER = r_rollover;

    stopwatch_time_counter_chk u_chk (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_DIGITS   (r_digits),
        .i_TICK     (r_tick),
        .i_ROLLOVER (r_rollover)
    );

endmodule

// Invariants of the time counter outputs: digits stay in BCD range and a rollover
// only ever accompanies a tick landing on 00:00.00.
module stopwatch_time_counter_chk (
    input logic        i_CLK,
    input logic        i_RST,
    input logic [23:0] i_DIGITS,
    input logic        i_TICK,
    input logic        i_ROLLOVER
);

    function automatic logic f_digits_valid(input logic [23:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) && (d[11:8] <= 4'd9) &&
               (d[15:12] <= 4'd5) && (d[19:16] <= 4'd9) && (d[23:20] <= 4'd5);
    endfunction

    a_digit_range : assert property (@(posedge i_CLK) disable iff (i_RST)
        f_digits_valid(i_DIGITS));

    a_roll_with_tick : assert property (@(posedge i_CLK) disable iff (i_RST)
        i_ROLLOVER |-> (i_TICK && (i_DIGITS == 24'h000000)));

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: a P_PRESCALE=10 instance for prescaler
// behaviour and a P_PRESCALE=1 instance for carry and rollover behaviour.
module tb_stopwatch_time_counter;

    logic        clk;
    logic        rst;
    logic        en0, clr0, en1, clr1;
    logic [23:0] digits0, digits1;
    logic        tick0, roll0, tick1, roll1;
    logic [23:0] preload_val;
    int          checks;
    int          failures;

    stopwatch_time_counter #(.P_PRESCALE(10), .P_PRESCALE_W(4)) dut (
        .i_CLK(clk), .i_RST(rst), .i_ENABLE(en0), .i_CLEAR(clr0),
        .o_DIGITS(digits0), .o_TICK(tick0), .o_ROLLOVER(roll0)
    );

    stopwatch_time_counter #(.P_PRESCALE(1), .P_PRESCALE_W(4)) dut1 (
        .i_CLK(clk), .i_RST(rst), .i_ENABLE(en1), .i_CLEAR(clr1),
        .o_DIGITS(digits1), .o_TICK(tick1), .o_ROLLOVER(roll1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b0; clr0 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        #2;
        checks++;
        if (digits0 !== 24'h000000 || tick0 !== 1'b0 || roll0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut0 got=%h/%b/%b exp=000000/0/0", digits0, tick0, roll0);
        end
        checks++;
        if (digits1 !== 24'h000000 || tick1 !== 1'b0 || roll1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h/%b/%b exp=000000/0/0", digits1, tick1, roll1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_tick();
        logic exp_tick;
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        en0  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_tick = (i == 9);
            checks++;
            if (tick0 !== exp_tick) begin
                failures++;
                $display("FAIL first_tick cycle=%0d got=%b exp=%b", i, tick0, exp_tick);
            end
        end
        checks++;
        if (digits0 !== 24'h000001) begin
            failures++;
            $display("FAIL first_tick_digits got=%h exp=000001", digits0);
        end
        en0 = 1'b0;
        @(negedge clk);
        checks++;
        if (tick0 !== 1'b0) begin
            failures++;
            $display("FAIL first_tick_pulse_width got=%b exp=0", tick0);
        end
    endtask

    task automatic test_pause();
        logic exp_tick;
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en0 = (i < 5) || (i >= 25);
            @(negedge clk);
            exp_tick = (i == 29);
            checks++;
            if (tick0 !== exp_tick) begin
                failures++;
                $display("FAIL pause_tick cycle=%0d got=%b exp=%b", i, tick0, exp_tick);
            end
        end
        checks++;
        if (digits0 !== 24'h000001) begin
            failures++;
            $display("FAIL pause_digits got=%h exp=000001", digits0);
        end
        en0 = 1'b0;
    endtask

    task automatic test_clear_priority();
        logic exp_tick;
        en0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (tick0 !== 1'b0) begin
                failures++;
                $display("FAIL clrpri_pre_tick cycle=%0d got=%b exp=0", i, tick0);
            end
        end
        clr0 = 1'b1;
        @(negedge clk);
        checks++;
        if (digits0 !== 24'h000000 || tick0 !== 1'b0 || roll0 !== 1'b0) begin
            failures++;
            $display("FAIL clrpri_clear got=%h/%b/%b exp=000000/0/0", digits0, tick0, roll0);
        end
        clr0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_tick = (i == 9);
            checks++;
            if (tick0 !== exp_tick) begin
                failures++;
                $display("FAIL clrpri_resume cycle=%0d got=%b exp=%b", i, tick0, exp_tick);
            end
        end
        checks++;
        if (digits0 !== 24'h000001) begin
            failures++;
            $display("FAIL clrpri_digits got=%h exp=000001", digits0);
        end
        en0 = 1'b0;
    endtask

    task automatic test_carry();
        int nticks;
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        en1  = 1'b1;
        nticks = 0;
        for (int i = 0; i < 999; i++) begin
            @(negedge clk);
            if (tick1 === 1'b1) nticks++;
        end
        checks++;
        if (nticks != 999) begin
            failures++;
            $display("FAIL carry_tick_count got=%0d exp=999", nticks);
        end
        checks++;
        if (digits1 !== 24'h000999) begin
            failures++;
            $display("FAIL carry_preload got=%h exp=000999", digits1);
        end
        @(negedge clk);
        checks++;
        if (digits1 !== 24'h001000 || tick1 !== 1'b1) begin
            failures++;
            $display("FAIL carry_h1_s0 got=%h/%b exp=001000/1", digits1, tick1);
        end
        en1 = 1'b0;
        @(negedge clk);
        checks++;
        if (digits1 !== 24'h001000 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL carry_hold got=%h/%b exp=001000/0", digits1, tick1);
        end
    endtask

    task automatic preload_dut1(input logic [23:0] val);
        en1 = 1'b0;
        preload_val = val;
        @(negedge clk);
        force dut1.r_digits = preload_val;
        @(negedge clk);
        release dut1.r_digits;
        @(negedge clk);
        checks++;
        if (digits1 !== val) begin
            failures++;
            $display("FAIL preload got=%h exp=%h", digits1, val);
        end
    endtask

    task automatic test_rollover();
        logic [23:0] exp_d;
        logic        exp_roll;
        int          nroll;
        preload_dut1(24'h095999);
        en1 = 1'b1;
        @(negedge clk);
        checks++;
        if (digits1 !== 24'h100000 || tick1 !== 1'b1 || roll1 !== 1'b0) begin
            failures++;
            $display("FAIL minute_carry got=%h/%b/%b exp=100000/1/0", digits1, tick1, roll1);
        end
        preload_dut1(24'h595990);
        en1 = 1'b1;
        nroll = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i < 9)       exp_d = 24'(24'h595991 + i);
            else if (i == 9) exp_d = 24'h000000;
            else             exp_d = 24'h000001;
            exp_roll = (i == 9);
            if (roll1 === 1'b1) nroll++;
            checks++;
            if (digits1 !== exp_d || tick1 !== 1'b1 || roll1 !== exp_roll) begin
                failures++;
                $display("FAIL rollover cycle=%0d got=%h/%b/%b exp=%h/1/%b",
                         i, digits1, tick1, roll1, exp_d, exp_roll);
            end
        end
        checks++;
        if (nroll != 1) begin
            failures++;
            $display("FAIL rollover_count got=%0d exp=1", nroll);
        end
        en1 = 1'b0;
        @(negedge clk);
        checks++;
        if (tick1 !== 1'b0 || roll1 !== 1'b0) begin
            failures++;
            $display("FAIL rollover_idle got=%b/%b exp=0/0", tick1, roll1);
        end
    endtask

    task automatic test_async_reset();
        en1 = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (digits1 !== 24'h000000 || tick1 !== 1'b0 || roll1 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_dut1 got=%h/%b/%b exp=000000/0/0", digits1, tick1, roll1);
        end
        checks++;
        if (digits0 !== 24'h000000) begin
            failures++;
            $display("FAIL async_reset_dut0 got=%h exp=000000", digits0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (digits1 !== 24'h000000 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got=%h/%b exp=000000/0", digits1, tick1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (digits1 !== 24'h000001 || tick1 !== 1'b1) begin
            failures++;
            $display("FAIL after_reset got=%h/%b exp=000001/1", digits1, tick1);
        end
        en1 = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        preload_val = 24'h000000;
        test_reset();
        test_first_tick();
        test_pause();
        test_clear_priority();
        test_carry();
        test_rollover();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
